// File: rtl/host_mux_pkg.sv
// rtl/host_mux_pkg.sv - shared types and round-robin pick for the host write mux
package host_mux_pkg;

   localparam int MAX_HOSTS = 8;
   localparam int CHAN_W    = 3;
   localparam int HOLD_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // First set bit at or above ptr, wrapping at n_hosts.
   function automatic logic [CHAN_W-1:0] rr_pick(input logic [MAX_HOSTS-1:0] pend,
                                                 input logic [CHAN_W-1:0]    ptr,
                                                 input int                   n_hosts);
      logic [CHAN_W-1:0] g;
      logic [CHAN_W-1:0] idx;
      logic              found;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_HOSTS; k++) begin
         idx = CHAN_W'((int'(ptr) + k) % n_hosts);
         if (!found && (k < n_hosts) && pend[idx]) begin
            g     = idx;
            found = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/host_mux_chan.sv
// rtl/host_mux_chan.sv - per-host edge detect, write latch, pending and sticky overrun
module host_mux_chan
   import host_mux_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int BANK_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [BANK_W-1:0] bank_i,
   input  logic              grant_clr_i,
   input  logic              clr_overrun_i,
   output logic [DATA_W-1:0] data_o,
   output logic [BANK_W-1:0] bank_o,
   output logic              pending_o,
   output logic              overrun_o
);

   logic              write_q;
   logic              req;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] data_q;
   logic [BANK_W-1:0] bank_q;

   assign req = write_i & ~write_q;

   // A request landing in the channel's own issue cycle refills the latch without counting as overrun.
   always_comb begin
      pending_d = req | (pending_q & ~grant_clr_i);
      overrun_d = overrun_q & ~clr_overrun_i;
      if (req && pending_q && !grant_clr_i) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q   <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         data_q    <= '0;
         bank_q    <= '0;
      end else begin
         write_q   <= write_i;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         if (req) begin
            data_q <= data_i;
            bank_q <= bank_i;
         end
      end
   end

   assign data_o    = data_q;
   assign bank_o    = bank_q;
   assign pending_o = pending_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/host_mux_rr.sv
// rtl/host_mux_rr.sv - N-host round-robin write mux with tick-paced forwarding
module host_mux_rr
   import host_mux_pkg::*;
#(
   parameter int N_HOSTS    = 2,
   parameter int DATA_W     = 256,
   parameter int BANK_W     = 8,
   parameter int HOLD_TICKS = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tick,
   input  logic [N_HOSTS*DATA_W-1:0] in_data,
   input  logic [N_HOSTS*BANK_W-1:0] in_bank,
   input  logic [N_HOSTS-1:0]        in_write,
   input  logic                      clr_overrun,
   output logic [DATA_W-1:0]         out_data,
   output logic [BANK_W-1:0]         out_bank,
   output logic [2:0]                out_chan,
   output logic                      out_write,
   output logic [N_HOSTS-1:0]        pending,
   output logic [N_HOSTS-1:0]        overrun
);

   state_e              state_q, state_d;
   logic [CHAN_W-1:0]   grant_q, grant_d;
   logic [CHAN_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [BANK_W-1:0]   out_bank_q, out_bank_d;
   logic [CHAN_W-1:0]   out_chan_q, out_chan_d;

   logic [DATA_W-1:0]   lat_data [N_HOSTS];
   logic [BANK_W-1:0]   lat_bank [N_HOSTS];
   logic [N_HOSTS-1:0]  grant_clr;
   logic [MAX_HOSTS-1:0] pend_ext;
   logic [DATA_W-1:0]   sel_data;
   logic [BANK_W-1:0]   sel_bank;
   logic                issuing;

   assign issuing = (state_q == ISSUE);

   for (genvar i = 0; i < N_HOSTS; i++) begin : g_chan
      assign grant_clr[i] = issuing && (grant_q == CHAN_W'(i));

      host_mux_chan #(
         .DATA_W (DATA_W),
         .BANK_W (BANK_W)
      ) u_chan (
         .clk           (clk),
         .rst_n         (rst_n),
         .write_i       (in_write[i]),
         .data_i        (in_data[i*DATA_W +: DATA_W]),
         .bank_i        (in_bank[i*BANK_W +: BANK_W]),
         .grant_clr_i   (grant_clr[i]),
         .clr_overrun_i (clr_overrun),
         .data_o        (lat_data[i]),
         .bank_o        (lat_bank[i]),
         .pending_o     (pending[i]),
         .overrun_o     (overrun[i])
      );
   end

   always_comb begin
      pend_ext                = '0;
      pend_ext[N_HOSTS-1:0]   = pending;
      sel_data                = '0;
      sel_bank                = '0;
      for (int i = 0; i < N_HOSTS; i++) begin
         if (grant_q == CHAN_W'(i)) begin
            sel_data = lat_data[i];
            sel_bank = lat_bank[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      hold_d     = hold_q;
      out_data_d = out_data_q;
      out_bank_d = out_bank_q;
      out_chan_d = out_chan_q;
      unique case (state_q)
         IDLE: begin
            if (|pending) begin
               grant_d = rr_pick(pend_ext, rr_ptr_q, N_HOSTS);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            out_data_d = sel_data;
            out_bank_d = sel_bank;
            out_chan_d = grant_q;
            rr_ptr_d   = (grant_q == CHAN_W'(N_HOSTS - 1)) ? '0 : grant_q + 3'd1;
            hold_d     = HOLD_W'(HOLD_TICKS);
            state_d    = HOLD;
         end
         HOLD: begin
            if (hold_q == '0) begin
               state_d = IDLE;
            end else if (tick) begin
               hold_d = hold_q - 8'd1;
               if (hold_q == 8'd1) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         hold_q     <= '0;
         out_data_q <= '0;
         out_bank_q <= '0;
         out_chan_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_q     <= hold_d;
         out_data_q <= out_data_d;
         out_bank_q <= out_bank_d;
         out_chan_q <= out_chan_d;
      end
   end

   // The issue cycle reads the latch live, so a same-cycle refill is forwarded only on the next grant.
   assign out_write = issuing;
   assign out_data  = issuing ? sel_data : out_data_q;
   assign out_bank  = issuing ? sel_bank : out_bank_q;
   assign out_chan  = issuing ? grant_q  : out_chan_q;

endmodule

// File: tb/tb_host_mux_rr.sv
// tb/tb_host_mux_rr.sv - scoreboard bench for the round-robin host write mux
module tb_host_mux_rr;

   localparam int N  = 4;
   localparam int DW = 256;
   localparam int BW = 8;
   localparam int HT = 2;
   localparam int TP = 16;

   typedef struct {
      logic [2:0]    chan;
      logic [BW-1:0] bank;
      logic [DW-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            tick = 1'b0;
   logic            clr_overrun = 1'b0;
   logic [N*DW-1:0] in_data = '0;
   logic [N*BW-1:0] in_bank = '0;
   logic [N-1:0]    in_write = '0;
   logic [DW-1:0]   out_data;
   logic [BW-1:0]   out_bank;
   logic [2:0]      out_chan;
   logic            out_write;
   logic [N-1:0]    pending;
   logic [N-1:0]    overrun;

   exp_t sbq[$];
   exp_t e_mon;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   n_writes = 0;
   int   spurious = 0;
   int   ticks_since = 1000;
   int   last_wr_cyc = 0;

   host_mux_rr #(
      .N_HOSTS    (N),
      .DATA_W     (DW),
      .BANK_W     (BW),
      .HOLD_TICKS (HT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .in_data     (in_data),
      .in_bank     (in_bank),
      .in_write    (in_write),
      .clr_overrun (clr_overrun),
      .out_data    (out_data),
      .out_bank    (out_bank),
      .out_chan    (out_chan),
      .out_write   (out_write),
      .pending     (pending),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         repeat (TP - 1) @(posedge clk);
         #1 tick = 1'b1;
         @(posedge clk);
         #1 tick = 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         ticks_since = 1000;
      end else if (out_write) begin
         n_writes++;
         last_wr_cyc = cyc;
         check_eq("spacing", DW'(ticks_since >= HT), 1);
         ticks_since = 0;
         if (sbq.size() == 0) begin
            spurious++;
         end else begin
            e_mon = sbq.pop_front();
            check_eq("out_chan", DW'(out_chan), DW'(e_mon.chan));
            check_eq("out_bank", DW'(out_bank), DW'(e_mon.bank));
            check_eq("out_data", out_data, e_mon.data);
         end
      end else if (tick) begin
         ticks_since++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      in_write    = '0;
      clr_overrun = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic set_chan(input int ch, input logic [DW-1:0] d, input logic [BW-1:0] b);
      in_data[ch*DW +: DW] = d;
      in_bank[ch*BW +: BW] = b;
   endtask

   task automatic push_exp(input int ch, input logic [DW-1:0] d, input logic [BW-1:0] b);
      exp_t e;
      e.chan = 3'(ch);
      e.bank = b;
      e.data = d;
      sbq.push_back(e);
   endtask

   task automatic pulse(input int ch, input logic [DW-1:0] d, input logic [BW-1:0] b);
      set_chan(ch, d, b);
      in_write[ch] = 1'b1;
      step();
      in_write[ch] = 1'b0;
      step();
   endtask

   task automatic wait_writes(input string tag, input int target, input int budget);
      int k = 0;
      while (n_writes < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq(tag, DW'(n_writes), DW'(target));
   endtask

   initial begin
      int t0;
      int w0;

      // reset with strobes toggling
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_write = N'($urandom);
         step();
      end
      @(negedge clk);
      check_eq("rst_out_write", DW'(out_write), 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_bank", DW'(out_bank), 0);
      check_eq("rst_out_chan", DW'(out_chan), 0);
      check_eq("rst_pending", DW'(pending), 0);
      check_eq("rst_overrun", DW'(overrun), 0);
      in_write = '0;
      step();
      rst_n = 1'b1;
      w0 = n_writes;
      repeat (20) step();
      check_eq("rst_quiet", DW'(n_writes), DW'(w0));

      // single write with latency
      w0 = n_writes;
      set_chan(1, 256'h2A, 8'd3);
      in_write[1] = 1'b1;
      t0 = cyc;
      push_exp(1, 256'h2A, 8'd3);
      step();
      check_eq("single_pend_set", DW'(pending[1]), 1);
      step();
      step();
      in_write[1] = 1'b0;
      wait_writes("single_wait", w0 + 1, 50);
      check_eq("single_latency", DW'(last_wr_cyc - t0), 2);
      repeat (30) step();
      check_eq("single_count", DW'(n_writes), DW'(w0 + 1));
      check_eq("single_pend_clr", DW'(pending), 0);
      check_eq("single_data_hold", out_data, 256'h2A);

      // all four channels at once
      do_reset();
      w0 = n_writes;
      for (int i = 0; i < N; i++) begin
         set_chan(i, DW'(256 + i), BW'(16 + i));
         push_exp(i, DW'(256 + i), BW'(16 + i));
      end
      in_write = '1;
      step();
      step();
      in_write = '0;
      wait_writes("rr_wait", w0 + 4, 400);
      check_eq("rr_overrun", DW'(overrun), 0);
      check_eq("rr_pending", DW'(pending), 0);

      // overrun, set-wins-over-clear, then clear
      do_reset();
      w0 = n_writes;
      push_exp(1, 256'h55, 8'd5);
      pulse(1, 256'h55, 8'd5);
      wait_writes("ovr_first", w0 + 1, 50);
      pulse(0, 256'h11, 8'd1);
      pulse(0, 256'h22, 8'd2);
      check_eq("ovr_set0", DW'(overrun), 1);
      pulse(2, 256'h33, 8'd3);
      set_chan(2, 256'h44, 8'd4);
      in_write[2] = 1'b1;
      clr_overrun = 1'b1;
      step();
      in_write[2] = 1'b0;
      clr_overrun = 1'b0;
      step();
      check_eq("ovr_set_wins", DW'(overrun), 4);
      push_exp(2, 256'h44, 8'd4);
      push_exp(0, 256'h22, 8'd2);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      check_eq("ovr_clear", DW'(overrun), 0);
      wait_writes("ovr_wait", w0 + 3, 400);

      // request in the channel's own issue cycle
      do_reset();
      w0 = n_writes;
      set_chan(0, 256'hA1, 8'd1);
      push_exp(0, 256'hA1, 8'd1);
      in_write[0] = 1'b1;
      step();
      in_write[0] = 1'b0;
      step();
      set_chan(0, 256'hA2, 8'd2);
      push_exp(0, 256'hA2, 8'd2);
      in_write[0] = 1'b1;
      step();
      check_eq("coll_pending", DW'(pending[0]), 1);
      check_eq("coll_overrun", DW'(overrun), 0);
      in_write[0] = 1'b0;
      wait_writes("coll_wait", w0 + 2, 400);
      check_eq("coll_overrun_end", DW'(overrun), 0);

      // reset in the middle of hold
      do_reset();
      w0 = n_writes;
      push_exp(2, 256'h77, 8'd7);
      pulse(2, 256'h77, 8'd7);
      wait_writes("mid_first", w0 + 1, 50);
      pulse(1, 256'h66, 8'd6);
      check_eq("mid_pend", DW'(pending), 2);
      #3 rst_n = 1'b0;
      #1;
      check_eq("mid_pend_rst", DW'(pending), 0);
      repeat (2) step();
      rst_n = 1'b1;
      w0 = n_writes;
      repeat (60) step();
      check_eq("mid_quiet", DW'(n_writes), DW'(w0));
      push_exp(1, 256'h99, 8'd9);
      pulse(1, 256'h99, 8'd9);
      wait_writes("mid_new", w0 + 1, 50);

      repeat (5) step();
      check_eq("spurious", DW'(spurious), 0);
      check_eq("sb_left", DW'(sbq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
